iq_capture_buf: RTL and testbench



---
 rtl/iq_capture_buf.sv | 143 ++++++++++++++
 tb/tb_iq_capture_buf.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iq_capture_buf.sv
// I/Q capture buffer: de-interleaves the iq/in_xy stream, decimates pairs and
// records 2^aw pairs after arm + trigger into two RAMs for host readback.
module iq_capture_buf #(
    parameter int dw = 18,
    parameter int aw = 9,
    parameter int cw = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          iq,
    input  logic [dw-1:0] in_xy,
    input  logic          arm,
    input  logic          trig,
    input  logic [cw-1:0] dec,
    output logic          busy,
    output logic          done,
    output logic          err_seq,
    input  logic [aw:0]   rd_addr,
    output logic [dw-1:0] rd_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_CAPT,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [dw-1:0] ihold_q, ihold_d;
    logic          ivalid_q, ivalid_d;
    logic          err_q, err_d;
    logic [aw-1:0] wp_q, wp_d;
    logic [cw-1:0] dc_q, dc_d;
    logic [cw-1:0] decr_q, decr_d;
    logic [dw-1:0] rdata_q;

    logic          pair_v;
    logic          seq_bad;
    logic          live;
    logic          we;

    logic [dw-1:0] ram_i [0:(1<<aw)-1];
    logic [dw-1:0] ram_q [0:(1<<aw)-1];

    // A Q without a pending I, or an I overwriting a pending I, is out of order
    assign pair_v  = iq & ivalid_q;
    assign seq_bad = (iq & ~ivalid_q) | (~iq & ivalid_q);
    assign live    = (state_q == S_ARMED) || (state_q == S_CAPT);
    assign we      = (state_q == S_CAPT) && pair_v && (dc_q == '0) && !arm;

    always_comb begin
        state_d  = state_q;
        ihold_d  = ihold_q;
        ivalid_d = ivalid_q;
        err_d    = err_q;
        wp_d     = wp_q;
        dc_d     = dc_q;
        decr_d   = decr_q;

        if (!iq) begin
            ihold_d  = in_xy;
            ivalid_d = 1'b1;
        end else begin
            ivalid_d = 1'b0;
        end

        if (arm) begin
            state_d = S_ARMED;
            decr_d  = dec;
            dc_d    = '0;
            wp_d    = '0;
            err_d   = 1'b0;
        end else begin
            if (live && seq_bad)
                err_d = 1'b1;
            unique case (state_q)
                S_IDLE: ;
                S_ARMED: begin
                    if (trig)
                        state_d = S_CAPT;
                end
                S_CAPT: begin
                    if (pair_v) begin
                        if (dc_q == '0) begin
                            wp_d = wp_q + 1'b1;
                            dc_d = decr_q;
                            if (wp_q == {aw{1'b1}})
                                state_d = S_DONE;
                        end else begin
                            dc_d = dc_q - 1'b1;
                        end
                    end
                end
                S_DONE: ;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ihold_q  <= '0;
            ivalid_q <= 1'b0;
            err_q    <= 1'b0;
            wp_q     <= '0;
            dc_q     <= '0;
            decr_q   <= '0;
        end else begin
            state_q  <= state_d;
            ihold_q  <= ihold_d;
            ivalid_q <= ivalid_d;
            err_q    <= err_d;
            wp_q     <= wp_d;
            dc_q     <= dc_d;
            decr_q   <= decr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            ram_i[wp_q] <= ihold_q;
            ram_q[wp_q] <= in_xy;
        end
    end

    // Read sees the pre-write contents when the same entry is written
    always_ff @(posedge clk) begin
        if (rst)
            rdata_q <= '0;
        else if (rd_addr[0])
            rdata_q <= ram_q[rd_addr[aw:1]];
        else
            rdata_q <= ram_i[rd_addr[aw:1]];
    end

    assign busy    = live;
    assign done    = (state_q == S_DONE);
    assign err_seq = err_q;
    assign rd_data = rdata_q;

endmodule

// File: tb/tb_iq_capture_buf.sv
// Directed bench for iq_capture_buf (aw=4): capture, decimation, sequence
// errors, re-arm, arm+trig collision, reset mid-capture and readback timing.
module tb_iq_capture_buf;

    localparam int DW = 18;
    localparam int AW = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          iq;
    logic [DW-1:0] in_xy;
    logic          arm;
    logic          trig;
    logic [CW-1:0] dec;
    logic [AW:0]   rd_addr;
    logic          busy;
    logic          done;
    logic          err_seq;
    logic [DW-1:0] rd_data;

    int nvec = 0;
    int nerr = 0;

    iq_capture_buf #(.dw(DW), .aw(AW), .cw(CW)) dut (
        .clk    (clk),
        .rst    (rst),
        .iq     (iq),
        .in_xy  (in_xy),
        .arm    (arm),
        .trig   (trig),
        .dec    (dec),
        .busy   (busy),
        .done   (done),
        .err_seq(err_seq),
        .rd_addr(rd_addr),
        .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs change on the falling edge; outputs are sampled on the next one
    task automatic cyc(input logic q, input int x, input logic a, input logic t);
        iq    = q;
        in_xy = DW'(x);
        arm   = a;
        trig  = t;
        @(negedge clk);
        arm   = 1'b0;
        trig  = 1'b0;
    endtask

    task automatic pair(input int k, input logic a, input logic t_on_q);
        cyc(1'b0, k, a, 1'b0);
        cyc(1'b1, -k, 1'b0, t_on_q);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cyc(1'b0, 5, 1'b0, 1'b0);
        cyc(1'b1, -5, 1'b0, 1'b0);
        nvec++;
        if (busy !== 1'b0) begin
            nerr++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
        nvec++;
        if (done !== 1'b0) begin
            nerr++;
            $display("FAIL reset_done: got %b want 0", done);
        end
        nvec++;
        if (err_seq !== 1'b0) begin
            nerr++;
            $display("FAIL reset_err: got %b want 0", err_seq);
        end
        nvec++;
        if (rd_data !== '0) begin
            nerr++;
            $display("FAIL reset_rd_data: got %h want 0", rd_data);
        end
        rst = 1'b0;
    endtask

    task automatic test_idle_glitch;
        cyc(1'b0, 1, 1'b0, 1'b0);
        cyc(1'b0, 2, 1'b0, 1'b0);
        cyc(1'b1, -2, 1'b0, 1'b0);
        cyc(1'b1, -3, 1'b0, 1'b0);
        nvec++;
        if (err_seq !== 1'b0) begin
            nerr++;
            $display("FAIL idle_glitch_err: got %b want 0", err_seq);
        end
        nvec++;
        if (busy !== 1'b0) begin
            nerr++;
            $display("FAIL idle_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_basic;
        dec = '0;
        pair(1, 1'b1, 1'b0);
        nvec++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            nerr++;
            $display("FAIL basic_armed: got busy=%b done=%b want 1/0", busy, done);
        end
        for (int k = 2; k <= 4; k++) pair(k, 1'b0, 1'b0);
        pair(5, 1'b0, 1'b1);
        for (int k = 6; k <= 20; k++) pair(k, 1'b0, 1'b0);
        nvec++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            nerr++;
            $display("FAIL basic_15_stores: got busy=%b done=%b want 1/0", busy, done);
        end
        pair(21, 1'b0, 1'b0);
        nvec++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            nerr++;
            $display("FAIL basic_done: got busy=%b done=%b want 0/1", busy, done);
        end
        nvec++;
        if (err_seq !== 1'b0) begin
            nerr++;
            $display("FAIL basic_err: got %b want 0", err_seq);
        end
    endtask

    task automatic test_readback;
        logic [DW-1:0] exp;
        int v;
        for (int a = 0; a < (1 << (AW + 1)); a++) begin
            rd_addr = (AW + 1)'(a);
            @(negedge clk);
            v = 6 + a / 2;
            exp = (a % 2 == 1) ? DW'(-v) : DW'(v);
            nvec++;
            if (rd_data !== exp) begin
                nerr++;
                $display("FAIL readback_addr%0d: got %0d want %0d",
                         a, $signed(rd_data), $signed(exp));
            end
        end
    endtask

    task automatic test_decimation;
        logic [DW-1:0] exp;
        int v;
        dec = 8'd3;
        pair(1, 1'b1, 1'b1);
        dec = 8'd0;
        for (int k = 2; k <= 61; k++) pair(k, 1'b0, 1'b0);
        nvec++;
        if (done !== 1'b0) begin
            nerr++;
            $display("FAIL dec_early_done: got %b want 0", done);
        end
        pair(62, 1'b0, 1'b0);
        nvec++;
        if (done !== 1'b1) begin
            nerr++;
            $display("FAIL dec_done: got %b want 1", done);
        end
        for (int a = 0; a < (1 << (AW + 1)); a++) begin
            rd_addr = (AW + 1)'(a);
            @(negedge clk);
            v = 2 + 4 * (a / 2);
            exp = (a % 2 == 1) ? DW'(-v) : DW'(v);
            nvec++;
            if (rd_data !== exp) begin
                nerr++;
                $display("FAIL dec_read_addr%0d: got %0d want %0d",
                         a, $signed(rd_data), $signed(exp));
            end
        end
    endtask

    task automatic test_seq_err;
        dec = '0;
        pair(1, 1'b1, 1'b0);
        cyc(1'b0, 2, 1'b0, 1'b0);
        cyc(1'b0, 2, 1'b0, 1'b0);
        nvec++;
        if (err_seq !== 1'b1) begin
            nerr++;
            $display("FAIL seq_err_set: got %b want 1", err_seq);
        end
        cyc(1'b1, -2, 1'b0, 1'b0);
        pair(3, 1'b0, 1'b1);
        for (int k = 4; k <= 19; k++) pair(k, 1'b0, 1'b0);
        nvec++;
        if (done !== 1'b1 || err_seq !== 1'b1) begin
            nerr++;
            $display("FAIL seq_err_done: got done=%b err=%b want 1/1", done, err_seq);
        end
    endtask

    task automatic test_rearm;
        dec = '0;
        pair(1, 1'b1, 1'b0);
        nvec++;
        if (err_seq !== 1'b0) begin
            nerr++;
            $display("FAIL rearm_err_clear: got %b want 0", err_seq);
        end
        pair(2, 1'b0, 1'b1);
        for (int k = 3; k <= 9; k++) pair(k, 1'b0, 1'b0);
        pair(10, 1'b1, 1'b0);
        nvec++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            nerr++;
            $display("FAIL rearm_state: got busy=%b done=%b want 1/0", busy, done);
        end
        pair(11, 1'b0, 1'b1);
        for (int k = 12; k <= 26; k++) pair(k, 1'b0, 1'b0);
        nvec++;
        if (done !== 1'b0) begin
            nerr++;
            $display("FAIL rearm_early_done: got %b want 0", done);
        end
        pair(27, 1'b0, 1'b0);
        nvec++;
        if (done !== 1'b1) begin
            nerr++;
            $display("FAIL rearm_done: got %b want 1", done);
        end
        rd_addr = 5'd1;
        @(negedge clk);
        nvec++;
        if (rd_data !== DW'(-12)) begin
            nerr++;
            $display("FAIL rearm_q0: got %0d want -12", $signed(rd_data));
        end
        rd_addr = 5'd12;
        @(negedge clk);
        nvec++;
        if (rd_data !== DW'(18)) begin
            nerr++;
            $display("FAIL rearm_i6: got %0d want 18", $signed(rd_data));
        end
    endtask

    task automatic test_arm_trig;
        rd_addr = 5'd0;
        cyc(1'b0, 30, 1'b1, 1'b1);
        cyc(1'b1, -30, 1'b0, 1'b0);
        for (int k = 31; k <= 33; k++) pair(k, 1'b0, 1'b0);
        nvec++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            nerr++;
            $display("FAIL armtrig_state: got busy=%b done=%b want 1/0", busy, done);
        end
        nvec++;
        if (rd_data !== DW'(12)) begin
            nerr++;
            $display("FAIL armtrig_no_store: got %0d want 12", $signed(rd_data));
        end
        pair(34, 1'b0, 1'b1);
        pair(35, 1'b0, 1'b0);
        nvec++;
        if (rd_data !== DW'(12)) begin
            nerr++;
            $display("FAIL read_before_write: got %0d want 12", $signed(rd_data));
        end
        pair(36, 1'b0, 1'b0);
        nvec++;
        if (rd_data !== DW'(35)) begin
            nerr++;
            $display("FAIL armtrig_first_store: got %0d want 35", $signed(rd_data));
        end
    endtask

    task automatic test_rst_mid;
        pair(37, 1'b0, 1'b0);
        rst = 1'b1;
        cyc(1'b0, 38, 1'b0, 1'b0);
        rst = 1'b0;
        nvec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            nerr++;
            $display("FAIL rst_mid_state: got busy=%b done=%b want 0/0", busy, done);
        end
        nvec++;
        if (rd_data !== '0) begin
            nerr++;
            $display("FAIL rst_mid_rd_data: got %h want 0", rd_data);
        end
        cyc(1'b1, -38, 1'b0, 1'b0);
        nvec++;
        if (err_seq !== 1'b0) begin
            nerr++;
            $display("FAIL rst_idle_err: got %b want 0", err_seq);
        end
        dec = '0;
        pair(40, 1'b1, 1'b0);
        pair(41, 1'b0, 1'b1);
        for (int k = 42; k <= 56; k++) pair(k, 1'b0, 1'b0);
        nvec++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            nerr++;
            $display("FAIL rst_recap_early: got busy=%b done=%b want 1/0", busy, done);
        end
        pair(57, 1'b0, 1'b0);
        nvec++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            nerr++;
            $display("FAIL rst_recap_done: got busy=%b done=%b want 0/1", busy, done);
        end
        rd_addr = 5'd31;
        @(negedge clk);
        nvec++;
        if (rd_data !== DW'(-57)) begin
            nerr++;
            $display("FAIL rst_recap_q15: got %0d want -57", $signed(rd_data));
        end
    endtask

    initial begin
        rst     = 1'b1;
        iq      = 1'b0;
        in_xy   = '0;
        arm     = 1'b0;
        trig    = 1'b0;
        dec     = '0;
        rd_addr = '0;
        @(negedge clk);
        test_reset;
        test_idle_glitch;
        test_basic;
        test_readback;
        test_decimation;
        test_seq_err;
        test_rearm;
        test_arm_trig;
        test_rst_mid;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
